// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD-to-binary decoder (bcd_to_b10) and its
// per-digit adjust cell (bcd_digit_sub3).
//   BCD_DIGIT_W : bits per BCD digit
//   BCD_ADJ     : correction subtracted from a digit >= 8 after a right shift
//   bcd_state_e : control FSM encoding
//   bcd_bin_w() : binary width needed for a DIGITS-digit BCD word
// ---------------------------------------------------------------------------
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_ADJ     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  // ceil(log2(10^digits)): width of the largest value 10^digits - 1
  function automatic int bcd_bin_w(input int digits);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// ---------------------------------------------------------------------------
// bcd_digit_sub3
// Reverse double-dabble digit correction: after a right shift, a digit that
// reads >= 8 received a bit worth 8 that actually stood for 5 (half of ten),
// so 3 is taken off. Purely combinational, modulo 16, no borrow out.
//   d_i : shifted 4-bit digit
//   d_o : corrected 4-bit digit
// ---------------------------------------------------------------------------
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  assign d_o = d_i[BCD_DIGIT_W-1] ? (d_i - BCD_DIGIT_W'(BCD_ADJ)) : d_i;

endmodule

// File: rtl/bcd_to_b10.sv
// ---------------------------------------------------------------------------
// bcd_to_b10
// Sequential BCD-to-binary decoder using reverse double-dabble, one bit per
// clock. A packed BCD word is taken over a valid/ready handshake, shifted
// right BIN_W times into a binary register (digits >= 8 get -3 after every
// shift), then the result is offered over a second valid/ready handshake.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   bcd_in is valid
//   in_ready   out  ready to accept a word (IDLE only)
//   bcd_in     in   packed BCD, digit k at [4k+3:4k]
//   out_valid  out  bin_out / err valid (DONE)
//   out_ready  in   consumer takes the result
//   bin_out    out  binary result, holds the last result outside DONE
//   err        out  illegal digit seen (range-check build only, else 0)
//
// Optional feature: define BCD_RANGE_CHECK_EN to flag digits > 9. A flagged
// word still takes the normal latency but returns bin_out = 0 with err = 1.
//
// Timing: accept edge N, shift edges N+1..N+BIN_W, result transferred to the
// output register on edge N+BIN_W+1 where out_valid rises.
// ---------------------------------------------------------------------------
module bcd_to_b10
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = bcd_bin_w(DIGITS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BIN_W-1:0]            bin_out,
  output logic                        err
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  // counts 0..BIN_W: BIN_W shifts, then one transfer cycle
  localparam int CNT_W = $clog2(BIN_W + 1);

  bcd_state_e       state_q, state_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] bcd_sh, bcd_adj;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BIN_W-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             shift_done;
  logic             err_flag;

  assign shift_done = (cnt_q == CNT_W'(BIN_W));

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = SHIFT;
      SHIFT:   if (shift_done) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // ---- FSM outputs ----
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // ---- shift datapath ----
  // LSB of the BCD register moves into the binary MSB; the BCD side is then
  // corrected digit by digit.
  assign bcd_sh = {1'b0, bcd_q[BCD_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .d_i (bcd_sh [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    bcd_d = bcd_q;
    bin_d = bin_q;
    cnt_d = cnt_q;
    res_d = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bcd_d = bcd_in;
          bin_d = '0;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        if (!shift_done) begin
          bcd_d = bcd_adj;
          bin_d = {bcd_q[0], bin_q[BIN_W-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // flagged words present zero instead of a meaningless value
          res_d = err_flag ? '0 : bin_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      bcd_q <= bcd_d;
      bin_q <= bin_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end

  assign bin_out = res_q;

`ifdef BCD_RANGE_CHECK_EN
  logic err_q, err_d, bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_in[k*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) bad_digit = 1'b1;
    end
  end

  // latched at accept, dropped on the edge that leaves DONE
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && in_valid) begin
      err_d = bad_digit;
    end else if (state_q == DONE && out_ready) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_flag = err_q;
`else
  assign err_flag = 1'b0;
`endif

  assign err = err_flag & out_valid;

endmodule

// File: tb/tb_bcd_to_b10.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_b10
// Self-checking bench for bcd_to_b10 (DIGITS=4, BIN_W=14): reset state,
// table of known words, randomized legal words against an arithmetic model,
// backpressure, back-to-back handshakes, illegal digits and reset mid-run.
// ---------------------------------------------------------------------------
module tb_bcd_to_b10;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int LAT    = 15;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [4*DIGITS-1:0] bcd_in;
  logic              out_valid;
  logic              out_ready;
  logic [BIN_W-1:0]  bin_out;
  logic              err;

  int checks;
  int errors;

  bcd_to_b10 #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    int          value;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // decimal value of a packed BCD word
  function automatic int bcd_value(input logic [15:0] w);
    int v;
    int scale;
    v = 0;
    scale = 1;
    for (int k = 0; k < DIGITS; k++) begin
      v = v + int'(w[4*k +: 4]) * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s ready timeout: in_ready=%0d after %0d cycles", tag, in_ready, n);
    end
  endtask

  task automatic convert(input logic [15:0] w, input int exp_bin, input bit chk_bin,
                         input bit exp_err, input string tag);
    int cyc;
    wait_ready(tag);
    in_valid = 1'b1;
    bcd_in   = w;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, " latency"}, cyc, LAT);
    if (chk_bin) chk({tag, " bin_out"}, bin_out, exp_bin);
    chk({tag, " err"}, err, exp_err);
    chk({tag, " in_ready in DONE"}, in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " out_valid after accept"}, out_valid, 0);
    chk({tag, " in_ready after accept"}, in_ready, 1);
  endtask

  initial begin
    logic [15:0] w;
    int cyc;
    int extra;
    bit exp_bad;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd_in    = '0;

    vecs[0] = '{16'h0000, 0};
    vecs[1] = '{16'h9999, 9999};
    vecs[2] = '{16'h1234, 1234};
    vecs[3] = '{16'h0005, 5};
    vecs[4] = '{16'h0100, 100};
    vecs[5] = '{16'h8765, 8765};
    vecs[6] = '{16'h0009, 9};
    vecs[7] = '{16'h5080, 5080};

    // reset state
    repeat (3) tick();
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset bin_out", bin_out, 0);
    chk("reset err", err, 0);
    rst_n = 1'b1;
    tick();

    // fixed table
    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].word, vecs[i].value, 1'b1, 1'b0, $sformatf("table[%0d]", i));
    end

    // random legal words against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < DIGITS; k++) w[4*k +: 4] = 4'($urandom_range(0, 9));
      convert(w, bcd_value(w), 1'b1, 1'b0, $sformatf("rand[%0d] %h", i, w));
    end

    // backpressure: result held stable while out_ready stays low
    wait_ready("bp");
    in_valid = 1'b1;
    bcd_in   = 16'h0420;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("bp latency", cyc, LAT);
    for (int i = 0; i < 20; i++) begin
      chk("bp out_valid", out_valid, 1);
      chk("bp bin_out", bin_out, 420);
      chk("bp in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp out_valid drop", out_valid, 0);
    chk("bp in_ready back", in_ready, 1);
    chk("bp bin_out holds", bin_out, 420);

    // back-to-back with in_valid held high
    out_ready = 1'b1;
    wait_ready("b2b");
    in_valid = 1'b1;
    bcd_in   = 16'h0001;
    tick();
    bcd_in = 16'h0002;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("b2b first latency", cyc, LAT);
    chk("b2b first bin_out", bin_out, 1);
    tick();
    chk("b2b bubble in_ready", in_ready, 1);
    chk("b2b bubble out_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("b2b second accepted", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("b2b second latency", cyc, LAT);
    chk("b2b second bin_out", bin_out, 2);
    tick();
    out_ready = 1'b0;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) extra++;
      tick();
    end
    chk("b2b no extra results", extra, 0);

    // illegal digit
`ifdef BCD_RANGE_CHECK_EN
    exp_bad = 1'b1;
`else
    exp_bad = 1'b0;
`endif
    convert(16'h12A4, 0, exp_bad, exp_bad, "illegal 12A4");
    convert(16'h0077, 77, 1'b1, 1'b0, "legal after illegal");

    // reset in the middle of a conversion
    wait_ready("rst");
    in_valid = 1'b1;
    bcd_in   = 16'h8765;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", in_ready, 1);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst bin_out", bin_out, 0);
    chk("midrst err", err, 0);
    tick();
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) extra++;
      tick();
    end
    chk("midrst no stale result", extra, 0);
    convert(16'h0100, 100, 1'b1, 1'b0, "after reset 0100");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
